// File: rtl/i2c_pkg.sv
// Shared types and constants for the burst-write I2C master.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_STOP
  } i2c_state_e;

  // Quarter-periods spent in each phase.
  localparam int unsigned Q_START = 2;
  localparam int unsigned Q_BIT   = 4;
  localparam int unsigned Q_STOP  = 3;

  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period tick: one-cycle pulse every CLK_DIV clocks while enabled,
// counter parked at zero when disabled.
module i2c_qtick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] cnt_q;

  assign tick = en && (cnt_q == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_burst.sv
// Write-only I2C master: START, address+W, then up to MAX_BYTES data bytes
// fetched one at a time through data_req, then STOP.
//
// state       | meaning
// ST_IDLE     | bus released, waiting for start_tx
// ST_START    | q0 scl/sda high, q1 sda low (start condition)
// ST_ADDR     | shifting out {slave_addr, W}
// ST_ADDR_ACK | sda released, ack_in sampled at end of q2
// ST_DATA     | shifting out the current data byte
// ST_DATA_ACK | sda released, ack_in sampled at end of q2
// ST_STOP     | q0 low/low, q1 scl high, q2 sda high (stop condition)
module i2c_master_burst
  import i2c_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 4,
  parameter int CW        = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_tx,
  input  logic [6:0]    slave_addr,
  input  logic [CW-1:0] byte_cnt,
  input  logic [7:0]    data_in,
  output logic          data_req,
  input  logic          ack_in,
  output logic          scl,
  output logic          sda,
  output logic          busy,
  output logic          done,
  output logic          nack_err
);

  i2c_state_e    state_q, state_d;
  logic [1:0]    qcnt_q;
  logic [1:0]    q_last;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [CW-1:0] cnt_lat_q;
  logic [CW-1:0] byte_idx_q;
  logic          ack_smp_q;
  logic          nack_q;
  logic          done_q;
  logic          armed_q;
  logic          tick;
  logic          slot_end;
  logic          accept;
  logic          in_shift;
  logic          in_ack;

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign nack_err = nack_q;
  assign in_shift = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign in_ack   = (state_q == ST_ADDR_ACK) || (state_q == ST_DATA_ACK);

  i2c_qtick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_qtick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tick (tick)
  );

  always_comb begin
    case (state_q)
      ST_START: q_last = 2'(Q_START - 1);
      ST_STOP:  q_last = 2'(Q_STOP - 1);
      default:  q_last = 2'(Q_BIT - 1);
    endcase
  end

  assign slot_end = tick && (qcnt_q == q_last);

  always_comb begin
    state_d  = state_q;
    scl      = 1'b1;
    sda      = 1'b1;
    data_req = 1'b0;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_tx && armed_q) begin
          accept  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        sda = (qcnt_q == 2'd0);
        if (slot_end) state_d = ST_ADDR;
      end
      ST_ADDR, ST_DATA: begin
        scl = qcnt_q[1];
        sda = shift_q[7];
        if (slot_end && (bit_q == 3'd7)) begin
          state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
        end
      end
      ST_ADDR_ACK, ST_DATA_ACK: begin
        scl = qcnt_q[1];
        if (slot_end) begin
          if (ack_smp_q || (byte_idx_q >= cnt_lat_q)) begin
            state_d = ST_STOP;
          end else begin
            data_req = 1'b1;
            state_d  = ST_DATA;
          end
        end
      end
      ST_STOP: begin
        scl = (qcnt_q != 2'd0);
        sda = (qcnt_q == 2'd2);
        if (slot_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A request is taken only after start_tx has been seen low since the last
  // accept or reset, so a level held across a transaction never retriggers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      qcnt_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      cnt_lat_q  <= '0;
      byte_idx_q <= '0;
      ack_smp_q  <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_STOP) && slot_end;
      if (!start_tx) armed_q <= 1'b1;
      if (tick) qcnt_q <= slot_end ? 2'd0 : qcnt_q + 2'd1;
      if (accept) begin
        armed_q    <= 1'b0;
        shift_q    <= {slave_addr, RW_WRITE};
        cnt_lat_q  <= (byte_cnt > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : byte_cnt;
        byte_idx_q <= '0;
        nack_q     <= 1'b0;
        qcnt_q     <= '0;
        bit_q      <= '0;
      end
      if (in_shift && slot_end) begin
        shift_q <= {shift_q[6:0], 1'b0};
        bit_q   <= bit_q + 3'd1;
      end
      if (in_ack && tick && (qcnt_q == 2'd2)) ack_smp_q <= ack_in;
      if (in_ack && slot_end && ack_smp_q) nack_q <= 1'b1;
      if (data_req) begin
        shift_q    <= data_in;
        byte_idx_q <= byte_idx_q + CW'(1);
      end
    end
  end

endmodule
